// File: rtl/cache_nway_if.sv
// Command/response bundle for the N-way cache array.
// master: drives addr, load, store, edit, invalid, flush, u_b_h_w, din.
// slave : returns registered hit, dout, valid, dirty, tag, victim_way and busy.
interface cache_nway_if #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 23,
  parameter int WAY_W     = 2
);
  logic [ADDR_BITS-1:0] addr;
  logic                 load;
  logic                 store;
  logic                 edit;
  logic                 invalid;
  logic                 flush;
  logic [2:0]           u_b_h_w;
  logic [31:0]          din;
  logic                 hit;
  logic [31:0]          dout;
  logic                 valid;
  logic                 dirty;
  logic [TAG_BITS-1:0]  tag;
  logic [WAY_W-1:0]     victim_way;
  logic                 busy;

  modport master (
    output addr, load, store, edit, invalid, flush, u_b_h_w, din,
    input  hit, dout, valid, dirty, tag, victim_way, busy
  );

  modport slave (
    input  addr, load, store, edit, invalid, flush, u_b_h_w, din,
    output hit, dout, valid, dirty, tag, victim_way, busy
  );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative cache array with true-LRU (per-way age) replacement
// and a flush-all sequencer that clears one set per cycle.
// Ports: clk, rst (async, active-low), bus (cache_nway_if.slave) carrying the
// load/store/edit/invalid/flush commands, access width, write data, and the
// registered hit/dout/valid/dirty/tag/victim_way results plus busy.
// LINE_WORDS is expected to be at least 2.
module cache_nway #(
  parameter int ADDR_BITS  = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  cache_nway_if.slave bus
);
  localparam int SET_W    = $clog2(SETS);
  localparam int WORD_W   = $clog2(LINE_WORDS);
  localparam int WAY_W    = $clog2(WAYS);
  localparam int TAG_BITS = ADDR_BITS - SET_W - WORD_W - 2;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state_reg, state_next;
  logic [SET_W-1:0] cnt_reg, cnt_next;

  logic [WAYS-1:0]     line_valid [SETS];
  logic [WAYS-1:0]     line_dirty [SETS];
  logic [WAY_W-1:0]    line_age   [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_mem    [SETS][WAYS];
  logic [31:0]         data_mem   [SETS][WAYS][LINE_WORDS];

  logic                hit_reg, valid_reg, dirty_reg;
  logic [31:0]         dout_reg;
  logic [TAG_BITS-1:0] tag_reg;
  logic [WAY_W-1:0]    victim_reg;

  logic [WORD_W-1:0]   word_idx;
  logic [SET_W-1:0]    set_idx;
  logic [TAG_BITS-1:0] addr_tag;
  logic [WAYS-1:0]     hit_vec;
  logic                hit_any, idle;
  logic [WAY_W-1:0]    hit_way, victim, sel_way, fill_way;
  logic [31:0]         hit_word, vic_word, load_val, merged;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic                do_inv, do_store, do_touch, do_edit;

  assign word_idx = bus.addr[2 +: WORD_W];
  assign set_idx  = bus.addr[2+WORD_W +: SET_W];
  assign addr_tag = bus.addr[ADDR_BITS-1 -: TAG_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = line_valid[set_idx][gi] && (tag_mem[set_idx][gi] == addr_tag);
    end
  endgenerate

  assign hit_any = |hit_vec;
  assign idle    = (state_reg == IDLE);

  always_comb begin
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
    // Oldest way first, then let any invalid way override; the descending
    // scan leaves the lowest-numbered invalid way as the final choice.
    for (int w = 0; w < WAYS; w++)
      if (line_age[set_idx][w] == WAY_W'(WAYS-1)) victim = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!line_valid[set_idx][w]) victim = WAY_W'(w);
  end

  assign sel_way  = hit_any ? hit_way : victim;
  // A store that already matches a line refills that line, so a multi-word
  // fill into a partly empty set stays in one way instead of spreading out.
  assign fill_way = hit_any ? hit_way : victim;
  assign hit_word = data_mem[set_idx][hit_way][word_idx];
  assign vic_word = data_mem[set_idx][victim][word_idx];

  // Lane extraction for loads and lane merge for edits share the same
  // width/offset rules: [1]=word, [0]=half, [2]=unsigned.
  always_comb begin
    byte_sel = hit_word[{bus.addr[1:0], 3'b000} +: 8];
    half_sel = bus.addr[1] ? hit_word[31:16] : hit_word[15:0];
    if (bus.u_b_h_w[1])
      load_val = hit_word;
    else if (bus.u_b_h_w[0])
      load_val = {{16{~bus.u_b_h_w[2] & half_sel[15]}}, half_sel};
    else
      load_val = {{24{~bus.u_b_h_w[2] & byte_sel[7]}}, byte_sel};

    merged = hit_word;
    if (bus.u_b_h_w[1])
      merged = bus.din;
    else if (bus.u_b_h_w[0])
      merged[{bus.addr[1], 4'b0000} +: 16] = bus.din[15:0];
    else
      merged[{bus.addr[1:0], 3'b000} +: 8] = bus.din[7:0];
  end

  // Priority: invalid > store > edit; a load's LRU touch rides with edit.
  assign do_inv   = idle & bus.invalid;
  assign do_store = idle & ~bus.invalid & bus.store;
  assign do_touch = idle & ~bus.invalid & ~bus.store & (bus.load | bus.edit) & hit_any;
  assign do_edit  = do_touch & bus.edit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (bus.flush) begin
        state_next = SCAN;
        cnt_next   = '0;
      end
      SCAN: if (cnt_reg == SET_W'(SETS-1)) state_next = DONE;
            else cnt_next = cnt_reg + 1'b1;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hit_reg    <= 1'b0;
      dout_reg   <= '0;
      valid_reg  <= 1'b0;
      dirty_reg  <= 1'b0;
      tag_reg    <= '0;
      victim_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        line_valid[s] <= '0;
        line_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) line_age[s][w] <= WAY_W'(w);
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (state_reg == SCAN) begin
        line_valid[cnt_reg] <= '0;
        line_dirty[cnt_reg] <= '0;
        for (int w = 0; w < WAYS; w++) line_age[cnt_reg][w] <= WAY_W'(w);
      end else if (do_inv) begin
        line_valid[set_idx] <= '0;
        line_dirty[set_idx] <= '0;
        for (int w = 0; w < WAYS; w++) line_age[set_idx][w] <= WAY_W'(w);
      end else if (do_store) begin
        line_valid[set_idx][fill_way] <= 1'b1;
        line_dirty[set_idx][fill_way] <= 1'b0;
      end else if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)
            line_age[set_idx][w] <= '0;
          else if (line_age[set_idx][w] < line_age[set_idx][hit_way])
            line_age[set_idx][w] <= line_age[set_idx][w] + 1'b1;
        end
        if (do_edit) line_dirty[set_idx][hit_way] <= 1'b1;
      end

      hit_reg    <= idle & hit_any;
      valid_reg  <= line_valid[set_idx][sel_way];
      dirty_reg  <= line_dirty[set_idx][sel_way];
      tag_reg    <= tag_mem[set_idx][sel_way];
      victim_reg <= victim;
      // load=0 exposes the raw victim word for the write-back path;
      // a load miss and any busy cycle leave dout unchanged.
      if (idle) begin
        if (!bus.load) dout_reg <= vic_word;
        else if (hit_any) dout_reg <= load_val;
      end
    end
  end

  // Data and tag storage carry no reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      data_mem[set_idx][fill_way][word_idx] <= bus.din;
      tag_mem[set_idx][fill_way]            <= addr_tag;
    end else if (do_edit) begin
      data_mem[set_idx][hit_way][word_idx] <= merged;
    end
  end

  assign bus.hit        = hit_reg;
  assign bus.dout       = dout_reg;
  assign bus.valid      = valid_reg;
  assign bus.dirty      = dirty_reg;
  assign bus.tag        = tag_reg;
  assign bus.victim_way = victim_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_cache_nway.sv
// Testbench for cache_nway: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a recency-list model.
module tb_cache_nway;
  localparam int ADDR_BITS  = 32;
  localparam int WAYS       = 4;
  localparam int SETS       = 32;
  localparam int LINE_WORDS = 4;
  localparam int TAG_BITS   = 23;
  localparam int WAY_W      = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_nway_if #(.ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .WAY_W(WAY_W)) bus ();

  cache_nway #(.ADDR_BITS(ADDR_BITS), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: per-line state plus a most-recent-first way list per set.
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LINE_WORDS];
  bit          m_known [SETS][WAYS][LINE_WORDS];
  int          recency [SETS][WAYS];
  int          busy_left;

  logic [31:0] e_dout, e_tag;
  logic [1:0]  e_vic;
  bit          e_hit, e_valid, e_dirty, e_dout_known, e_aux, e_tag_chk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int t, int s, int w, int off);
    return 32'((t << 9) | (s << 4) | (w << 2) | off);
  endfunction

  function automatic logic [31:0] extend(logic [31:0] w, logic [2:0] u, logic [1:0] off);
    logic [31:0] v;
    if (u[1]) return w;
    if (u[0]) begin
      v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
      if (!u[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    v = (w >> (8 * int'(off))) & 32'hFF;
    if (!u[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [2:0] u, logic [1:0] off);
    logic [31:0] mask, sh;
    if (u[1]) return d;
    if (u[0]) begin
      mask = 32'hFFFF << (16 * int'(off[1]));
      sh   = (d & 32'hFFFF) << (16 * int'(off[1]));
    end else begin
      mask = 32'hFF << (8 * int'(off));
      sh   = (d & 32'hFF) << (8 * int'(off));
    end
    return (w & ~mask) | sh;
  endfunction

  task automatic clear_set(int s);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[s][w] = 1'b0;
      m_dirty[s][w] = 1'b0;
      recency[s][w] = w;
    end
  endtask

  task automatic touch(int s, int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (recency[s][i] == w) p = i;
    for (int i = p; i > 0; i--) recency[s][i] = recency[s][i-1];
    recency[s][0] = w;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) clear_set(s);
    busy_left = 0;
    e_hit = 0; e_dout = '0; e_dout_known = 1; e_valid = 0; e_dirty = 0;
    e_tag = '0; e_tag_chk = 1; e_vic = '0; e_aux = 1;
  endtask

  task automatic model_step();
    int s, wi, h, v, sel, tw;
    logic [31:0] tg;
    logic [1:0] off;
    if (busy_left > 0) begin
      busy_left--;
      e_hit = 0;
      e_aux = 0;
      return;
    end
    s   = int'(bus.addr[8:4]);
    wi  = int'(bus.addr[3:2]);
    off = bus.addr[1:0];
    tg  = bus.addr >> 9;
    h = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) h = w;
    v = recency[s][WAYS-1];
    for (int w = WAYS-1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    sel = (h >= 0) ? h : v;
    e_hit = (h >= 0); e_valid = m_valid[s][sel]; e_dirty = m_dirty[s][sel];
    e_tag = m_tag[s][sel]; e_tag_chk = m_valid[s][sel]; e_vic = 2'(v); e_aux = 1;
    if (bus.load) begin
      if (h >= 0) begin
        e_dout = extend(m_data[s][h][wi], bus.u_b_h_w, off);
        e_dout_known = m_known[s][h][wi];
      end
    end else begin
      e_dout = m_data[s][v][wi];
      e_dout_known = m_known[s][v][wi];
    end
    if (bus.invalid) clear_set(s);
    else if (bus.store) begin
      tw = (h >= 0) ? h : v;
      m_data[s][tw][wi] = bus.din; m_known[s][tw][wi] = 1;
      m_valid[s][tw] = 1; m_dirty[s][tw] = 0; m_tag[s][tw] = tg;
    end else if ((bus.load || bus.edit) && h >= 0) begin
      touch(s, h);
      if (bus.edit) begin
        m_data[s][h][wi] = merge(m_data[s][h][wi], bus.din, bus.u_b_h_w, off);
        if (bus.u_b_h_w[1]) m_known[s][h][wi] = 1;
        m_dirty[s][h] = 1;
      end
    end
    if (bus.flush) begin
      busy_left = SETS + 1;
      for (int i = 0; i < SETS; i++) clear_set(i);
    end
  endtask

  // One clock: model advances at the edge, DUT outputs compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check("busy", 32'(bus.busy), 32'(busy_left > 0));
    check("hit", 32'(bus.hit), 32'(e_hit));
    if (e_dout_known) check("dout", bus.dout, e_dout);
    if (e_aux) begin
      check("valid", 32'(bus.valid), 32'(e_valid));
      check("dirty", 32'(bus.dirty), 32'(e_dirty));
      check("victim_way", 32'(bus.victim_way), 32'(e_vic));
      if (e_tag_chk) check("tag", 32'(bus.tag), e_tag);
    end
  endtask

  task automatic drive(bit ld, bit st, bit ed, bit inv, bit fl, logic [2:0] u,
                       logic [31:0] a, logic [31:0] d);
    bus.load = ld; bus.store = st; bus.edit = ed; bus.invalid = inv; bus.flush = fl;
    bus.u_b_h_w = u; bus.addr = a; bus.din = d;
    $display("txn ld=%0b st=%0b ed=%0b inv=%0b fl=%0b u=%0d addr=%h din=%h",
             ld, st, ed, inv, fl, u, a, d);
    tick();
  endtask

  logic [2:0] utab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  int         stab [3] = '{3, 7, 20};

  initial begin
    int cnt, r;
    logic [2:0] u;
    logic [31:0] a;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        for (int k = 0; k < LINE_WORDS; k++) m_known[s][w][k] = 0;
    rst = 1'b0;
    bus.load = 0; bus.store = 0; bus.edit = 0; bus.invalid = 0; bus.flush = 0;
    bus.u_b_h_w = 3'b010; bus.addr = '0; bus.din = '0;
    model_reset();
    tick(); tick();
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_victim", 32'(bus.victim_way), 32'd0);
    rst = 1'b1;

    drive(1, 0, 0, 0, 0, 3'b010, 32'h0000_0100, 32'd0);
    check("first_hit", 32'(bus.hit), 32'd0);
    check("first_valid", 32'(bus.valid), 32'd0);
    check("first_victim", 32'(bus.victim_way), 32'd0);
    check("first_busy", 32'(bus.busy), 32'd0);

    // Fill four ways of set 3 with tags 1..4, then touch them in order.
    for (int t = 1; t <= 4; t++)
      for (int w = 0; w < LINE_WORDS; w++)
        drive(0, 1, 0, 0, 0, 3'b010, mk(t, 3, w, 0), 32'((t << 16) | w));
    for (int t = 1; t <= 4; t++) begin
      drive(1, 0, 0, 0, 0, 3'b010, mk(t, 3, 1, 0), 32'd0);
      check("fill_hit", 32'(bus.hit), 32'd1);
      check("fill_dout", bus.dout, 32'((t << 16) | 1));
    end
    drive(0, 1, 0, 0, 0, 3'b010, mk(5, 3, 0, 0), 32'h5000_0000);
    check("evict_victim", 32'(bus.victim_way), 32'd0);
    check("evict_tag", 32'(bus.tag), 32'd1);
    check("evict_hit", 32'(bus.hit), 32'd0);

    // Load extension and edit merge in set 5.
    drive(0, 1, 0, 0, 0, 3'b010, mk(9, 5, 0, 0), 32'h8765_43F1);
    for (int t = 10; t <= 12; t++) drive(0, 1, 0, 0, 0, 3'b010, mk(t, 5, 0, 0), 32'd0);
    drive(1, 0, 0, 0, 0, 3'b000, mk(9, 5, 0, 0), 32'd0);
    check("lb", bus.dout, 32'hFFFF_FFF1);
    drive(1, 0, 0, 0, 0, 3'b100, mk(9, 5, 0, 0), 32'd0);
    check("lbu", bus.dout, 32'h0000_00F1);
    drive(1, 0, 0, 0, 0, 3'b001, mk(9, 5, 0, 2), 32'd0);
    check("lh_hi", bus.dout, 32'hFFFF_8765);
    drive(0, 0, 1, 0, 0, 3'b000, mk(9, 5, 0, 2), 32'h0000_00AA);
    check("edit_hit", 32'(bus.hit), 32'd1);
    drive(1, 0, 0, 0, 0, 3'b010, mk(9, 5, 0, 0), 32'd0);
    check("edit_word", bus.dout, 32'h87AA_43F1);
    check("edit_dirty", 32'(bus.dirty), 32'd1);
    for (int t = 10; t <= 12; t++) drive(1, 0, 0, 0, 0, 3'b010, mk(t, 5, 0, 0), 32'd0);
    drive(0, 0, 0, 0, 0, 3'b010, mk(9, 5, 0, 0), 32'd0);
    check("wb_dout", bus.dout, 32'h87AA_43F1);
    check("wb_dirty", 32'(bus.dirty), 32'd1);
    check("wb_victim", 32'(bus.victim_way), 32'd0);

    // Flush: count busy cycles while loads are ignored.
    drive(0, 0, 0, 0, 1, 3'b010, mk(30, 3, 0, 0), 32'd0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      check("busy_hit", 32'(bus.hit), 32'd0);
      drive(1, 0, 0, 0, 0, 3'b010, mk(1, 3, 0, 0), 32'd0);
    end
    check("flush_len", 32'(cnt), 32'd33);
    drive(1, 0, 0, 0, 0, 3'b010, mk(4, 3, 0, 0), 32'd0);
    check("post_flush_hit", 32'(bus.hit), 32'd0);
    check("post_flush_victim", 32'(bus.victim_way), 32'd0);
    drive(1, 0, 0, 0, 0, 3'b010, mk(9, 5, 0, 0), 32'd0);
    check("post_flush_hit5", 32'(bus.hit), 32'd0);

    // Reset in the middle of a flush.
    drive(0, 0, 0, 0, 1, 3'b010, mk(1, 1, 0, 0), 32'd0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 3'b010, mk(1, 1, 0, 0), 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    drive(0, 0, 0, 0, 0, 3'b010, mk(1, 1, 0, 0), 32'd0);
    rst = 1'b1;

    // Store and edit together: store wins.
    drive(0, 1, 0, 0, 0, 3'b010, mk(2, 7, 0, 0), 32'h1111_1111);
    drive(0, 1, 1, 0, 0, 3'b000, mk(2, 7, 0, 0), 32'h2222_2222);
    drive(1, 0, 0, 0, 0, 3'b010, mk(2, 7, 0, 0), 32'd0);
    check("se_dout", bus.dout, 32'h2222_2222);
    check("se_dirty", 32'(bus.dirty), 32'd0);
    check("se_hit", 32'(bus.hit), 32'd1);

    // Randomized traffic over a few sets and tags.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 199));
      u = utab[$urandom_range(0, 4)];
      a = mk(int'($urandom_range(1, 6)), stab[$urandom_range(0, 2)],
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (r < 80)       drive(1, 0, 0, 0, 0, u, a, $urandom);
      else if (r < 130) drive(0, 1, 0, 0, 0, u, a, $urandom);
      else if (r < 160) drive(0, 0, 1, 0, 0, u, a, $urandom);
      else if (r < 168) drive(0, 0, 0, 1, 0, u, a, $urandom);
      else if (r < 197) drive(0, 0, 0, 0, 0, u, a, $urandom);
      else              drive(0, 0, 0, 0, 1, u, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
